// File: rtl/pictochat_pkg.sv
// Shared types for the pictochat drawing path: screen bounds, coordinate
// widths, the packed segment record and the stroke tracker states.
package pictochat_pkg;

    localparam int SCREEN_COLS = 240;
    localparam int SCREEN_ROWS = 320;

    typedef logic [7:0] col_t;
    typedef logic [8:0] row_t;
    typedef logic [2:0] color_t;

    typedef struct packed {
        col_t   col1;
        col_t   col2;
        row_t   row1;
        row_t   row2;
        color_t color;
    } segment_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_DRAWING = 1'b1
    } state_t;

    // Saturate a raw touch column onto the visible screen
    function automatic col_t clamp_col(input col_t c);
        return (c > col_t'(SCREEN_COLS - 1)) ? col_t'(SCREEN_COLS - 1) : c;
    endfunction

    // Saturate a raw touch row onto the visible screen
    function automatic row_t clamp_row(input row_t r);
        return (r > row_t'(SCREEN_ROWS - 1)) ? row_t'(SCREEN_ROWS - 1) : r;
    endfunction

endpackage

// File: rtl/seg_fifo.sv
// Synchronous FIFO of segment_t. Pointers carry one extra wrap bit so full
// and empty are never ambiguous. A push while full is accepted only when a
// pop happens in the same cycle; otherwise it is ignored and the caller is
// expected to flag the drop. The head is read straight from the array so
// it is visible the cycle after the write, with no empty-path bypass.
module seg_fifo
    import pictochat_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  segment_t push_data,
    input  logic     pop,
    output segment_t head,
    output logic     empty,
    output logic     full
);

    localparam int AW = $clog2(DEPTH);

    segment_t       mem [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic           push_en;
    logic           pop_en;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    // Storage array; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers wrap naturally through the extra bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/stroke_segmenter.sv
// Turns a stream of touch samples into line segments for the display.
// Samples are clamped to the screen, a pen-down in IDLE emits a dot, each
// further pen-down emits a segment from the previous point, and pen-up ends
// the stroke. Segments queue in seg_fifo until the display accepts them.
// Optional macro STROKE_DECIMATE_EN drops pen-down samples closer than
// MIN_DIST (Manhattan) to the anchor while drawing.
module stroke_segmenter
    import pictochat_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_DIST   = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       sample_valid_in,
    input  logic [7:0] sample_col_in,
    input  logic [8:0] sample_row_in,
    input  logic       pen_down_in,
    input  logic [2:0] color_in,
    input  logic       seg_ready_in,
    output logic       seg_valid_out,
    output logic [7:0] col1_out,
    output logic [7:0] col2_out,
    output logic [8:0] row1_out,
    output logic [8:0] row2_out,
    output logic [2:0] color_out,
    output logic       overflow_out
);

    state_t   state_reg;
    col_t     anchor_col_reg;
    row_t     anchor_row_reg;
    logic     overflow_reg;

    col_t     sample_col;
    row_t     sample_row;
    logic     pen_down_sample;
    logic     pen_up_sample;
    logic     wants_push;
    logic     push_accepted;
    logic     push_dropped;
    logic     pop;
    segment_t seg_push;
    segment_t fifo_head;
    segment_t head_shown;
    logic     fifo_empty;
    logic     fifo_full;

    assign sample_col      = clamp_col(sample_col_in);
    assign sample_row      = clamp_row(sample_row_in);
    assign pen_down_sample = sample_valid_in && pen_down_in;
    assign pen_up_sample   = sample_valid_in && !pen_down_in;

`ifdef STROKE_DECIMATE_EN
    col_t       dist_col;
    row_t       dist_row;
    logic [9:0] dist_sum;
    logic       far_enough;

    assign dist_col   = (sample_col >= anchor_col_reg) ? (sample_col - anchor_col_reg)
                                                       : (anchor_col_reg - sample_col);
    assign dist_row   = (sample_row >= anchor_row_reg) ? (sample_row - anchor_row_reg)
                                                       : (anchor_row_reg - sample_row);
    assign dist_sum   = 10'(dist_col) + 10'(dist_row);
    assign far_enough = (int'({22'd0, dist_sum}) >= MIN_DIST);
    assign wants_push = pen_down_sample && ((state_reg == ST_IDLE) || far_enough);
`else
    // MIN_DIST only matters when decimation is built in
    if (MIN_DIST < 0) begin : g_min_dist_unused
    end
    assign wants_push = pen_down_sample;
`endif

    assign pop           = seg_valid_out && seg_ready_in;
    assign push_accepted = wants_push && (!fifo_full || pop);
    assign push_dropped  = wants_push && !push_accepted;

    // Build the outgoing segment: a dot from IDLE, else anchor-to-sample
    always_comb begin
        seg_push       = '0;
        seg_push.col2  = sample_col;
        seg_push.row2  = sample_row;
        seg_push.color = color_in;
        if (state_reg == ST_IDLE) begin
            seg_push.col1 = sample_col;
            seg_push.row1 = sample_row;
        end else begin
            seg_push.col1 = anchor_col_reg;
            seg_push.row1 = anchor_row_reg;
        end
    end

    // Stroke tracker: anchor and state move only on an accepted push
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg      <= ST_IDLE;
            anchor_col_reg <= '0;
            anchor_row_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            overflow_reg <= push_dropped;
            if (pen_up_sample) begin
                state_reg <= ST_IDLE;
            end else if (push_accepted) begin
                state_reg      <= ST_DRAWING;
                anchor_col_reg <= sample_col;
                anchor_row_reg <= sample_row;
            end
        end
    end

    seg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_seg_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (wants_push),
        .push_data (seg_push),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Head fields read as zero whenever nothing is queued
    assign head_shown    = fifo_empty ? '0 : fifo_head;
    assign seg_valid_out = !fifo_empty;
    assign col1_out      = head_shown.col1;
    assign col2_out      = head_shown.col2;
    assign row1_out      = head_shown.row1;
    assign row2_out      = head_shown.row2;
    assign color_out     = head_shown.color;
    assign overflow_out  = overflow_reg;

endmodule

// File: tb/tb_stroke_segmenter.sv
// Self-checking bench for stroke_segmenter. A queue-based model of the
// stroke rules predicts the head segment, valid and overflow each cycle.
module tb_stroke_segmenter;

    localparam int DEPTH = 4;
    localparam int MIN_D = 2;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       sample_valid_in = 1'b0;
    logic [7:0] sample_col_in = '0;
    logic [8:0] sample_row_in = '0;
    logic       pen_down_in = 1'b0;
    logic [2:0] color_in = '0;
    logic       seg_ready_in = 1'b0;
    logic       seg_valid_out;
    logic [7:0] col1_out;
    logic [7:0] col2_out;
    logic [8:0] row1_out;
    logic [8:0] row2_out;
    logic [2:0] color_out;
    logic       overflow_out;

    stroke_segmenter #(
        .FIFO_DEPTH (DEPTH),
        .MIN_DIST   (MIN_D)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_valid_in (sample_valid_in),
        .sample_col_in   (sample_col_in),
        .sample_row_in   (sample_row_in),
        .pen_down_in     (pen_down_in),
        .color_in        (color_in),
        .seg_ready_in    (seg_ready_in),
        .seg_valid_out   (seg_valid_out),
        .col1_out        (col1_out),
        .col2_out        (col2_out),
        .row1_out        (row1_out),
        .row2_out        (row2_out),
        .color_out       (color_out),
        .overflow_out    (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int c1;
        int c2;
        int r1;
        int r2;
        int color;
    } seg_m_t;

    seg_m_t q[$];
    bit     m_anchored = 1'b0;
    int     m_ac = 0;
    int     m_ar = 0;
    bit     m_ovf = 1'b0;

    function automatic bit model_far(input int c, input int r);
`ifdef STROKE_DECIMATE_EN
        int d;
        d = ((c > m_ac) ? c - m_ac : m_ac - c) + ((r > m_ar) ? r - m_ar : m_ar - r);
        return d >= MIN_D;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [38:0] obs_vec();
        if (seg_valid_out === 1'b1)
            return {1'b1, col1_out, col2_out, row1_out, row2_out, color_out, overflow_out};
        return {seg_valid_out, 37'd0, overflow_out};
    endfunction

    function automatic logic [38:0] exp_vec();
        if (q.size() > 0)
            return {1'b1, 8'(q[0].c1), 8'(q[0].c2), 9'(q[0].r1), 9'(q[0].r2),
                    3'(q[0].color), m_ovf};
        return {1'b0, 37'd0, m_ovf};
    endfunction

    // Apply one cycle of inputs (called at a falling edge), step the model,
    // and return at the next falling edge.
    task automatic drive(input bit v, input bit p, input int c, input int r,
                         input int col, input bit rdy);
        int  cc;
        int  rr;
        bit  want;
        seg_m_t s;
        sample_valid_in = v;
        pen_down_in     = p;
        sample_col_in   = c[7:0];
        sample_row_in   = r[8:0];
        color_in        = col[2:0];
        seg_ready_in    = rdy;
        cc = (c > 239) ? 239 : c;
        rr = (r > 319) ? 319 : r;
        m_ovf = 1'b0;
        want = v && p && (!m_anchored || model_far(cc, rr));
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (want) begin
            if (q.size() < DEPTH) begin
                s.c1 = m_anchored ? m_ac : cc;
                s.r1 = m_anchored ? m_ar : rr;
                s.c2 = cc;
                s.r2 = rr;
                s.color = col;
                q.push_back(s);
                m_ac = cc;
                m_ar = rr;
                m_anchored = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (v && !p) m_anchored = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
    endtask

    task automatic test_reset();
        sample_valid_in = 1'b0;
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({seg_valid_out, overflow_out, col1_out, col2_out, row1_out, row2_out, color_out} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b ovf=%b c1=%0d c2=%0d r1=%0d r2=%0d col=%0d required all zero",
                     seg_valid_out, overflow_out, col1_out, col2_out, row1_out, row2_out, color_out);
        end
        rst_in = 1'b1;
        $display("reset released");
    endtask

    task automatic test_dot();
        drive(1'b1, 1'b1, 100, 200, 5, 1'b0);
        checks++;
        if ({seg_valid_out, col1_out, col2_out, row1_out, row2_out, color_out} !==
            {1'b1, 8'd100, 8'd100, 9'd200, 9'd200, 3'd5}) begin
            errors++;
            $display("FAIL dot got v=%b (%0d,%0d)-(%0d,%0d) col=%0d required v=1 (100,200)-(100,200) col=5",
                     seg_valid_out, col1_out, row1_out, col2_out, row2_out, color_out);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL dot_model got %h required %h", obs_vec(), exp_vec());
        end
        $display("dot: v=%b (%0d,%0d)", seg_valid_out, col1_out, row1_out);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        drain();
    endtask

    task automatic test_stroke();
        int pts[4][2] = '{'{100, 200}, '{150, 250}, '{0, 0}, '{50, 60}};
        bit pen[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pen[i], pts[i][0], pts[i][1], 3, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stroke_%0d got %h required %h", i, obs_vec(), exp_vec());
            end
            $display("stroke %0d: v=%b (%0d,%0d)-(%0d,%0d)", i, seg_valid_out,
                     col1_out, row1_out, col2_out, row2_out);
        end
        checks++;
        if ({col1_out, col2_out} !== {8'd50, 8'd50}) begin
            errors++;
            $display("FAIL stroke_new_dot got c1=%0d c2=%0d required 50 50", col1_out, col2_out);
        end
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        drain();
    endtask

    task automatic test_clamp();
        drive(1'b1, 1'b1, 255, 400, 1, 1'b1);
        checks++;
        if ({seg_valid_out, col1_out, col2_out, row1_out, row2_out} !==
            {1'b1, 8'd239, 8'd239, 9'd319, 9'd319}) begin
            errors++;
            $display("FAIL clamp got v=%b (%0d,%0d)-(%0d,%0d) required (239,319)-(239,319)",
                     seg_valid_out, col1_out, row1_out, col2_out, row2_out);
        end
        $display("clamp: (%0d,%0d)", col1_out, row1_out);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        drain();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 10 + 10 * i, 20 + 10 * i, i, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_push_%0d got %h required %h", i, obs_vec(), exp_vec());
            end
            $display("overflow push %0d: v=%b ovf=%b", i, seg_valid_out, overflow_out);
        end
        checks++;
        if (overflow_out !== 1'b1) begin
            errors++;
            $display("FAIL overflow_pulse got %b required 1", overflow_out);
        end
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        checks++;
        if (overflow_out !== 1'b0) begin
            errors++;
            $display("FAIL overflow_one_cycle got %b required 0", overflow_out);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_drain_%0d got %h required %h", i, obs_vec(), exp_vec());
            end
        end
        drive(1'b1, 1'b1, 200, 100, 2, 1'b0);
        checks++;
        if ({col1_out, row1_out, col2_out} !== {8'd40, 9'd50, 8'd200}) begin
            errors++;
            $display("FAIL overflow_anchor got c1=%0d r1=%0d c2=%0d required 40 50 200",
                     col1_out, row1_out, col2_out);
        end
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        drain();
    endtask

    task automatic test_decimate();
        drive(1'b1, 1'b1, 100, 200, 4, 1'b1);
        drain();
        drive(1'b1, 1'b1, 101, 200, 4, 1'b1);
        checks++;
`ifdef STROKE_DECIMATE_EN
        if (seg_valid_out !== 1'b0) begin
`else
        if (seg_valid_out !== 1'b1) begin
`endif
            errors++;
            $display("FAIL decimate_near got v=%b", seg_valid_out);
        end
        drain();
        drive(1'b1, 1'b1, 102, 200, 4, 1'b1);
        checks++;
`ifdef STROKE_DECIMATE_EN
        if ({seg_valid_out, col1_out, col2_out} !== {1'b1, 8'd100, 8'd102}) begin
`else
        if ({seg_valid_out, col1_out, col2_out} !== {1'b1, 8'd101, 8'd102}) begin
`endif
            errors++;
            $display("FAIL decimate_far got v=%b c1=%0d c2=%0d", seg_valid_out, col1_out, col2_out);
        end
        $display("decimate: v=%b c1=%0d c2=%0d", seg_valid_out, col1_out, col2_out);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 30 + i * 5, 40, 6, 1'b0);
        checks++;
        if (seg_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_queued got v=%b required 1", seg_valid_out);
        end
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({seg_valid_out, col1_out, row1_out} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid_async got v=%b c1=%0d r1=%0d required 0 0 0",
                     seg_valid_out, col1_out, row1_out);
        end
        q.delete();
        m_anchored = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        drive(1'b1, 1'b1, 77, 88, 2, 1'b0);
        checks++;
        if ({seg_valid_out, col1_out, col2_out, row1_out, row2_out} !==
            {1'b1, 8'd77, 8'd77, 9'd88, 9'd88}) begin
            errors++;
            $display("FAIL reset_mid_dot got v=%b (%0d,%0d)-(%0d,%0d) required (77,88)-(77,88)",
                     seg_valid_out, col1_out, row1_out, col2_out, row2_out);
        end
        $display("reset mid: dot (%0d,%0d)", col1_out, row1_out);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit p;
            bit rdy;
            v   = ($urandom_range(0, 9) < 6);
            p   = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 4);
            drive(v, p, int'($urandom_range(0, 255)), int'($urandom_range(0, 511)),
                  int'($urandom_range(0, 7)), rdy);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_%0d got %h required %h", i, obs_vec(), exp_vec());
            end
            $display("random %0d: v=%b p=%b rdy=%b -> valid=%b ovf=%b depth=%0d", i, v, p, rdy,
                     seg_valid_out, overflow_out, q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        @(negedge clk_in);
        test_dot();
        test_stroke();
        test_clamp();
        test_overflow();
        test_decimate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stroke_segmenter.md
STROKE_SEGMENTER -- requirements
Module: stroke_segmenter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the number of segment entries buffered (power of two, at least 2).
REQ-002 SHALL have parameter MIN_DIST, default 2, the Manhattan-distance threshold used only when STROKE_DECIMATE_EN is defined.
REQ-003 SHALL have port clk_in  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port sample_valid_in  input  1  one-cycle strobe marking a touch sample.
REQ-006 SHALL have port sample_col_in  input  8  sample column.
REQ-007 SHALL have port sample_row_in  input  9  sample row.
REQ-008 SHALL have port pen_down_in  input  1  pen contact flag, qualified by sample_valid_in.
REQ-009 SHALL have port color_in  input  3  current brush colour, captured with each pushed segment.
REQ-010 SHALL have port seg_ready_in  input  1  the downstream display accepts the head segment.
REQ-011 SHALL have port seg_valid_out  output  1  the head segment is valid.
REQ-012 SHALL have port col1_out, col2_out  output  8 each  segment endpoint columns.
REQ-013 SHALL have port row1_out, row2_out  output  9 each  segment endpoint rows.
REQ-014 SHALL have port color_out  output  3  segment colour.
REQ-015 SHALL have port overflow_out  output  1  one-cycle pulse when a segment is dropped.

Function
REQ-016 SHALL clamp each sample before any other use: column above 239 becomes 239, row above 319 becomes 319.
REQ-017 SHALL implement state IDLE (no anchor point) and state DRAWING (anchor point held).
REQ-018 In IDLE, on a pen-down sample, SHALL push a dot segment (col1=col2=c, row1=row2=r), set the anchor to (c,r) and go to DRAWING.
REQ-019 In DRAWING, on a pen-down sample, SHALL push the segment from the anchor to (c,r) and then set the anchor to (c,r).
REQ-020 In any state, on a pen-up sample, SHALL go to IDLE without pushing.
REQ-021 SHALL ignore the sample inputs while sample_valid_in is low.
REQ-022 SHALL present the FIFO head on the outputs, with seg_valid_out high exactly while the FIFO is non-empty.
REQ-023 SHALL pop the FIFO on any cycle where seg_valid_out and seg_ready_in are both high.
REQ-024 SHALL hold all segment outputs stable while seg_valid_out is high and seg_ready_in is low.
REQ-025 SHALL raise seg_valid_out in cycle N+1 when a sample is accepted in cycle N into an empty FIFO.
REQ-026 On a push to a full FIFO with no pop in the same cycle, SHALL drop the segment, pulse overflow_out for one cycle, and leave the state and anchor unchanged.
REQ-027 On a push and a pop in the same cycle while the FIFO is full, SHALL accept the push with no overflow.
REQ-028 On a push and a pop in the same cycle while the FIFO is empty, SHALL not bypass: the pushed entry appears in the next cycle.
REQ-029 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH and keep full and empty unambiguous, using one extra pointer bit.

Reset
REQ-030 While rst_in is low, SHALL force: state IDLE, FIFO empty, seg_valid_out 0, overflow_out 0, all segment outputs 0.
REQ-031 An assertion of rst_in mid-operation SHALL discard every queued segment and the anchor immediately, asynchronously.
REQ-032 SHALL act on the first sample on the first rising clock edge after rst_in deasserts.

Configuration
REQ-033 SHALL provide the macro STROKE_DECIMATE_EN.
REQ-034 With STROKE_DECIMATE_EN defined, in DRAWING, a pen-down sample with |c-anchor_col| + |r-anchor_row| below MIN_DIST SHALL be discarded: no push, anchor unchanged.
REQ-035 Without STROKE_DECIMATE_EN, every pen-down sample in DRAWING SHALL push, even a zero-length segment, and no distance logic SHALL be synthesised.

Structure
REQ-036 Package pictochat_pkg SHALL hold SCREEN_COLS (240), SCREEN_ROWS (320), col_t (8 bits), row_t (9 bits), color_t (3 bits) and the packed segment_t struct {col1, col2, row1, row2, color}.
REQ-037 SHALL instantiate one sub-module, seg_fifo, a synchronous FIFO of segment_t parameterised by FIFO_DEPTH; clamp, the state machine and decimation stay in the top level.

Verification
REQ-038 Reset, then a pen-down sample (100,200) with colour 5 -> one cycle later seg_valid_out is 1 with col1=col2=100, row1=row2=200, color_out=5.
REQ-039 Pen-down samples (100,200) then (150,250), with seg_ready_in high -> dot segment, then segment 100->150 / 200->250; a following pen-up returns to IDLE, and the next pen-down yields a dot.
REQ-040 Sample (255,400) -> clamped segment at (239,319).
REQ-041 seg_ready_in held low and 5 pen-down samples with FIFO_DEPTH 4 -> 4 entries queued, overflow_out pulses once, the 5th segment is dropped, and the anchor stays at the 4th point.
REQ-042 With STROKE_DECIMATE_EN defined, anchor (100,200) then sample (101,200) -> no push; sample (102,200) -> segment 100->102; without the macro, both samples push.
REQ-043 rst_in pulsed low with 3 queued segments -> seg_valid_out 0 immediately, and the next pen-down produces a dot.
